ram_bist: RTL and testbench

- Initiator-side engine for the team's 4-bit-wide, 8-bit-addressed synchronous RAM interface: EN, RW, address, data_in, and registered data_out.
- On a start pulse, runs a four-pass March-style test and reports pass/fail plus first-failure diagnostics:
  - write pattern
  - read/verify pattern
  - write inverted pattern
  - read/verify inverted pattern
- Sits between the system controller and the RAM; it owns the RAM's interface while busy.

---
 rtl/ram_bist_if.sv | 25 ++
 rtl/ram_bist.sv | 173 +++++++++++++++++
 tb/tb_ram_bist.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bist_if.sv
// ram_bist_if: synchronous RAM bus (4-bit data, 8-bit address) between the
// BIST engine and the RAM.
//   mem_en    - RAM enable
//   mem_rw    - 1 = write, 0 = read
//   mem_addr  - word address
//   mem_wdata - write data
//   mem_rdata - registered read data, valid the cycle after a read
// master: the engine driving the bus; slave: the RAM.
interface ram_bist_if;
  logic       mem_en;
  logic       mem_rw;
  logic [7:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;

  modport master (
    output mem_en, mem_rw, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en, mem_rw, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ram_bist.sv
// ram_bist: March-style built-in self test for a 4-bit x 8-bit-address RAM.
// A start pulse in IDLE runs four passes: write PATTERN, read/verify PATTERN,
// write ~PATTERN, read/verify ~PATTERN, then pulses done and reports the result.
//   clk, rst_n      - clock, asynchronous active-low reset
//   start           - run request, honoured only in IDLE
//   busy            - high while the four passes are running
//   done            - one-cycle completion pulse
//   pass            - result of the last completed run
//   err_count       - miscompares in the current/last run, saturating at 255
//   fail_addr/data  - address and read data of the first miscompare
//   fail_phase      - 0 = first miscompare in PATTERN pass, 1 = in ~PATTERN pass
//   mem             - RAM bus (master side), all outputs registered
module ram_bist #(
  parameter int         DEPTH   = 128,
  parameter logic [3:0] PATTERN = 4'hA
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] fail_addr,
  output logic [3:0] fail_data,
  output logic       fail_phase,
  ram_bist_if.master mem
);

  typedef enum logic [2:0] {IDLE, WR0, RD0, DR0, WR1, RD1, DR1, FIN} state_t;

  // Terminal address compared on the 8-bit counter, so DEPTH = 256 ends at 0xFF.
  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic       en_q, en_d;
  logic       rw_q, rw_d;
  logic [3:0] wdata_q, wdata_d;
  logic       cmp_vld_q, cmp_vld_d;
  logic [7:0] cmp_addr_q, cmp_addr_d;
  logic [3:0] cmp_exp_q, cmp_exp_d;
  logic       cmp_phase_q, cmp_phase_d;
  logic       pass_q, pass_d;
  logic [7:0] err_q, err_d;
  logic [7:0] fail_addr_q, fail_addr_d;
  logic [3:0] fail_data_q, fail_data_d;
  logic       fail_phase_q, fail_phase_d;
  logic       miscmp;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    fail_phase_d = fail_phase_q;
    // A read issued this cycle is checked next cycle, when its data arrives.
    cmp_vld_d    = 1'b0;
    cmp_addr_d   = addr_q;
    cmp_exp_d    = (state_q == RD1) ? ~PATTERN : PATTERN;
    cmp_phase_d  = (state_q == RD1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WR0;
          addr_d  = 8'd0;
        end
      end
      WR0, WR1: begin
        if (addr_q == LAST_ADDR) begin
          state_d = (state_q == WR0) ? RD0 : RD1;
          addr_d  = 8'd0;
        end else begin
          addr_d = addr_q + 8'd1;
        end
      end
      RD0, RD1: begin
        cmp_vld_d = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = (state_q == RD0) ? DR0 : DR1;
          addr_d  = 8'd0;
        end else begin
          addr_d = addr_q + 8'd1;
        end
      end
      DR0: begin
        state_d = WR1;
        addr_d  = 8'd0;
      end
      DR1:     state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered from the next state, so they line up with it.
    en_d    = state_d inside {WR0, RD0, WR1, RD1};
    rw_d    = state_d inside {WR0, WR1};
    wdata_d = (state_d == WR0) ? PATTERN : ((state_d == WR1) ? ~PATTERN : 4'h0);

    miscmp = cmp_vld_q && (mem.mem_rdata != cmp_exp_q);
    if (state_q == IDLE && start) begin
      err_d        = 8'd0;
      fail_addr_d  = 8'd0;
      fail_data_d  = 4'h0;
      fail_phase_d = 1'b0;
      pass_d       = 1'b0;
    end else if (miscmp) begin
      err_d = sat_inc(err_q);
      // err_q never wraps, so zero means this is the run's first miscompare.
      if (err_q == 8'd0) begin
        fail_addr_d  = cmp_addr_q;
        fail_data_d  = mem.mem_rdata;
        fail_phase_d = cmp_phase_q;
      end
    end
    // Final verdict includes the last compare made in DR1.
    if (state_q == DR1) pass_d = (err_d == 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= 8'd0;
      en_q         <= 1'b0;
      rw_q         <= 1'b0;
      wdata_q      <= 4'h0;
      cmp_vld_q    <= 1'b0;
      cmp_addr_q   <= 8'd0;
      cmp_exp_q    <= 4'h0;
      cmp_phase_q  <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= 8'd0;
      fail_addr_q  <= 8'd0;
      fail_data_q  <= 4'h0;
      fail_phase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      en_q         <= en_d;
      rw_q         <= rw_d;
      wdata_q      <= wdata_d;
      cmp_vld_q    <= cmp_vld_d;
      cmp_addr_q   <= cmp_addr_d;
      cmp_exp_q    <= cmp_exp_d;
      cmp_phase_q  <= cmp_phase_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;
      fail_phase_q <= fail_phase_d;
    end
  end

  assign busy          = state_q inside {WR0, RD0, DR0, WR1, RD1, DR1};
  assign done          = (state_q == FIN);
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign fail_addr     = fail_addr_q;
  assign fail_data     = fail_data_q;
  assign fail_phase    = fail_phase_q;
  assign mem.mem_en    = en_q;
  assign mem.mem_rw    = rw_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_ram_bist.sv
module tb_ram_bist;
  localparam int         DEPTH    = 128;
  localparam logic [3:0] PAT      = 4'hA;
  localparam int         BUSY_LEN = 2 * (2 * DEPTH + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, pass, fail_phase;
  logic [7:0] err_count, fail_addr;
  logic [3:0] fail_data;

  ram_bist_if bus ();

  ram_bist #(.DEPTH(DEPTH), .PATTERN(PAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_phase(fail_phase),
    .mem(bus)
  );

  always #5 clk = ~clk;

  // RAM model. mode: 0 good, 1 addr 5 bit0 stuck-at-0, 2 rdata stuck 0,
  // 3 read data one cycle late, 4 per-address stuck masks s0/s1.
  int         mode = 0;
  logic [3:0] s0 [256];
  logic [3:0] s1 [256];
  logic [3:0] ram [256];
  logic [3:0] rd_q, late_q;
  logic [7:0] wlog_a [$];
  logic [3:0] wlog_d [$];

  function automatic logic [3:0] faulty(input logic [3:0] d, input logic [7:0] a);
    case (mode)
      1:       return (a == 8'h05) ? (d & 4'hE) : d;
      4:       return (d & ~s0[a]) | s1[a];
      default: return d;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= 4'h0;
      late_q <= 4'h0;
    end else begin
      if (bus.mem_en && bus.mem_rw) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        wlog_a.push_back(bus.mem_addr);
        wlog_d.push_back(bus.mem_wdata);
      end
      if (bus.mem_en && !bus.mem_rw) rd_q <= faulty(ram[bus.mem_addr], bus.mem_addr);
      late_q <= rd_q;
    end
  end

  assign bus.mem_rdata = (mode == 2) ? 4'h0 : ((mode == 3) ? late_q : rd_q);

  // Cycle-accurate tallies of busy cycles and done pulses.
  int busy_tot = 0, done_tot = 0;
  always @(negedge clk) begin
    if (busy) busy_tot <= busy_tot + 1;
    if (done) done_tot <= done_tot + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulses start (caller at a negedge, DUT in IDLE), waits for done, checks result.
  task automatic run_check(input string nm, input int e_err, input int e_addr,
                           input int e_data, input int e_phase, input int e_pass,
                           input bit wiggle);
    int b0, d0;
    bit seen;
    b0 = busy_tot; d0 = done_tot; seen = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      if (wiggle && busy) start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, int'(seen), 1);
    chk({nm, "_busy_at_done"}, int'(busy), 0);
    chk({nm, "_err"}, int'(err_count), e_err);
    chk({nm, "_fail_addr"}, int'(fail_addr), e_addr);
    chk({nm, "_fail_data"}, int'(fail_data), e_data);
    chk({nm, "_fail_phase"}, int'(fail_phase), e_phase);
    chk({nm, "_pass"}, int'(pass), e_pass);
    @(negedge clk);
    chk({nm, "_busy_len"}, busy_tot - b0, BUSY_LEN);
    chk({nm, "_done_pulses"}, done_tot - d0, 1);
    chk({nm, "_pass_held"}, int'(pass), e_pass);
  endtask

  // Reference: expected result of a run from the per-address stuck masks.
  task automatic ref_model(output int e, output int a, output int d, output int p);
    int cnt;
    logic [3:0] exp_v, got;
    cnt = 0; a = 0; d = 0; p = 0;
    for (int ph = 0; ph < 2; ph++) begin
      exp_v = (ph == 1) ? ~PAT : PAT;
      for (int ad = 0; ad < DEPTH; ad++) begin
        got = (exp_v & ~s0[ad]) | s1[ad];
        if (got != exp_v) begin
          if (cnt == 0) begin a = ad; d = int'(got); p = ph; end
          cnt++;
        end
      end
    end
    e = (cnt > 255) ? 255 : cnt;
  endtask

  typedef struct {
    int    mode;
    int    err;
    int    addr;
    int    data;
    int    phase;
    int    pass;
    string name;
  } vec_t;

  vec_t tv [4];

  initial begin
    int w0, bad, e, a, d, p, d0, b0;
    bit found;
    tv[0] = '{0,   0, 0, 0, 0, 1, "good"};
    tv[1] = '{1,   1, 5, 4, 1, 0, "stuck_a5b0"};
    tv[2] = '{2, 255, 0, 0, 0, 0, "rdata_zero"};
    tv[3] = '{3,   2, 0, 0, 0, 0, "late_read"};
    for (int i = 0; i < 256; i++) begin s0[i] = 4'h0; s1[i] = 4'h0; end

    // Asynchronous reset, before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ctrl", int'({busy, done, pass, fail_phase}), 0);
    chk("rst_diag", int'({err_count, fail_addr, fail_data}), 0);
    chk("rst_bus", int'({bus.mem_en, bus.mem_rw, bus.mem_addr, bus.mem_wdata}), 0);
    repeat (3) @(negedge clk);
    chk("rst_hold_busy", int'(busy | bus.mem_en), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven directed fault models.
    for (int i = 0; i < 4; i++) begin
      mode = tv[i].mode;
      do_reset();
      w0 = wlog_a.size();
      run_check(tv[i].name, tv[i].err, tv[i].addr, tv[i].data, tv[i].phase, tv[i].pass, 1'b0);
      if (tv[i].mode == 0) begin
        chk("wr_count", wlog_a.size() - w0, 2 * DEPTH);
        bad = 0;
        for (int k = 0; k < 2 * DEPTH && w0 + k < wlog_a.size(); k++)
          if (int'(wlog_a[w0 + k]) != (k % DEPTH) || wlog_d[w0 + k] != ((k < DEPTH) ? PAT : ~PAT))
            bad++;
        chk("wr_order", bad, 0);
      end
    end

    // Randomized stuck-at faults, back-to-back runs (start must clear history).
    mode = 4;
    for (int r = 0; r < 6; r++) begin
      for (int ad = 0; ad < 256; ad++) begin
        if (r == 5) begin
          s0[ad] = 4'h0; s1[ad] = 4'hF;
        end else if ($urandom_range(0, 15) == 0) begin
          s0[ad] = 4'($urandom_range(0, 15)); s1[ad] = 4'($urandom_range(0, 15));
        end else begin
          s0[ad] = 4'h0; s1[ad] = 4'h0;
        end
      end
      ref_model(e, a, d, p);
      run_check($sformatf("rand%0d", r), e, a, d, p, int'(e == 0), 1'b0);
    end

    // Reset in the middle of RD0 at address 0x40.
    for (int ad = 0; ad < 256; ad++) begin s0[ad] = 4'h0; s1[ad] = 4'h0; end
    s1[3] = 4'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (bus.mem_en && !bus.mem_rw && bus.mem_addr == 8'h40) begin found = 1'b1; break; end
    end
    chk("midrst_reached", int'(found), 1);
    chk("midrst_pre_err", int'(err_count), 1);
    d0 = done_tot;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", int'({busy, done, pass, fail_phase}), 0);
    chk("midrst_diag", int'({err_count, fail_addr, fail_data}), 0);
    chk("midrst_bus", int'({bus.mem_en, bus.mem_rw, bus.mem_addr, bus.mem_wdata}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_tot - d0, 0);
    chk("midrst_idle", int'(busy), 0);
    run_check("after_rst", 1, 3, 4'hB, 0, 0, 1'b0);

    // start held high across a run: rerun only from IDLE after FIN.
    mode = 0;
    start = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done) begin found = 1'b1; break; end
    end
    chk("held_done1", int'(found), 1);
    @(negedge clk);
    chk("held_idle_gap", int'(busy | done), 0);
    b0 = busy_tot; d0 = done_tot;
    @(negedge clk);
    chk("held_restart", int'(busy), 1);
    found = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done) begin found = 1'b1; break; end
    end
    start = 1'b0;
    chk("held_done2", int'(found), 1);
    chk("held_pass", int'(pass), 1);
    @(negedge clk);
    chk("held_busy_len", busy_tot - b0, BUSY_LEN);
    chk("held_done_pulses", done_tot - d0, 1);

    // Random start pulses while busy: one run, undisturbed counters.
    mode = 1;
    run_check("wiggle", 1, 5, 4, 1, 0, 1'b1);
    d0 = done_tot;
    repeat (10) @(negedge clk);
    chk("wiggle_no_rerun", done_tot - d0, 0);
    chk("wiggle_idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
